// File: rtl/car_input_pkg.sv
// Shared definitions for the push-button input path: channel indices,
// debounce FSM encoding and default timing.
package car_input_pkg;

  localparam int BTN_UP     = 4;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_MIDDLE = 0;

  localparam int DEF_N_BTN       = 5;
  localparam int DEF_DB_CYCLES   = 2_000_000;    // 20 ms at 100 MHz
  localparam int DEF_HOLD_CYCLES = 100_000_000;  // 1 s at 100 MHz

  typedef enum logic [1:0] {
    DB_LOW      = 2'd0,
    DB_CHK_HIGH = 2'd1,
    DB_HIGH     = 2'd2,
    DB_CHK_LOW  = 2'd3
  } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with hold timer,
// and registered level / rise / fall / long_press outputs.
//
// state       | meaning
// DB_LOW      | debounced level 0, waiting for s=1
// DB_CHK_HIGH | s went high, counting stable cycles before accepting
// DB_HIGH     | debounced level 1, hold timer running
// DB_CHK_LOW  | s went low, counting stable cycles before releasing
module debounce_channel
  import car_input_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  logic              sync_1;
  logic              s;
  db_state_t         state, state_next;
  logic [DB_W-1:0]   db_cnt, db_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              level_c;
  logic              long_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      s          <= 1'b0;
      state      <= DB_LOW;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync_1     <= btn_raw;
      s          <= sync_1;
      state      <= state_next;
      db_cnt     <= db_next;
      hold_cnt   <= hold_next;
      level      <= level_c;
      rise       <= level_c & ~level;
      fall       <= ~level_c & level;
      long_press <= long_c;
    end
  end

  // >= rather than == keeps DB_CYCLES=1 working: db_cnt enters at 1, above DB_LAST.
  always_comb begin
    state_next = state;
    db_next    = db_cnt;
    hold_next  = hold_cnt;
    case (state)
      DB_LOW: begin
        if (s) begin
          state_next = DB_CHK_HIGH;
          db_next    = DB_ONE;
        end
      end
      DB_CHK_HIGH: begin
        if (!s) begin
          state_next = DB_LOW;
          db_next    = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_next = DB_HIGH;
          db_next    = '0;
          hold_next  = '0;
        end else begin
          db_next = db_cnt + DB_ONE;
        end
      end
      DB_HIGH: begin
        if (!s) begin
          state_next = DB_CHK_LOW;
          db_next    = DB_ONE;
          hold_next  = '0;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_next = hold_cnt + HOLD_W'(1);
        end
      end
      DB_CHK_LOW: begin
        if (s) begin
          state_next = DB_HIGH;
          db_next    = '0;
          hold_next  = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_next = DB_LOW;
          db_next    = '0;
        end else begin
          db_next = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_next = DB_LOW;
        db_next    = '0;
        hold_next  = '0;
      end
    endcase
  end

  assign level_c = (state == DB_HIGH) || (state == DB_CHK_LOW);
  assign long_c  = (state == DB_HIGH) && (hold_cnt == HOLD_LAST);

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the board push-buttons, one independent
// debounce_channel per bit, MSB first {up, left, right, down, middle}.
module button_conditioner
  import car_input_pkg::*;
#(
  parameter int N_BTN       = DEF_N_BTN,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] fall,
  output logic [N_BTN-1:0] long_press
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .btn_raw   (btn_raw[g]),
      .level     (level[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .long_press(long_press[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: the driver steps a behavioural debounce model and queues
// the expected outputs; a monitor pops and compares after every clock edge.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int DB   = 4;
  localparam int HOLD = 10;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] lp;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] level, rise, fall, long_press;

  exp_t exp_q[$];
  bit   active = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // model state: raw delayed two edges, accepted level, run of disagreeing
  // samples, age of the current uninterrupted high run, last output level
  bit m_s1[N], m_s[N], m_lvl[N], m_out[N];
  int m_run[N], m_age[N];

  button_conditioner #(
    .N_BTN      (N),
    .DB_CYCLES  (DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .level     (level),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Expected outputs after the coming rising edge, then advance the model.
  task automatic model_step(input logic [N-1:0] raw, input logic rst, output exp_t e);
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        m_s1[i] = 0; m_s[i] = 0; m_lvl[i] = 0; m_out[i] = 0;
        m_run[i] = 0; m_age[i] = 0;
      end else begin
        e.level[i] = m_lvl[i];
        e.rise[i]  = m_lvl[i] && !m_out[i];
        e.fall[i]  = !m_lvl[i] && m_out[i];
        e.lp[i]    = m_lvl[i] && (m_run[i] == 0) && (m_age[i] == HOLD - 1);
        m_out[i]   = m_lvl[i];
        if (m_s[i] != m_lvl[i]) begin
          m_run[i]++;
          m_age[i] = 0;
          if (m_run[i] == DB) begin
            m_lvl[i] = !m_lvl[i];
            m_run[i] = 0;
          end
        end else begin
          if (m_lvl[i]) begin
            if (m_run[i] > 0) m_age[i] = 0;
            else if (m_age[i] < HOLD) m_age[i]++;
          end
          m_run[i] = 0;
        end
        m_s[i]  = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] raw, input logic rst, input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      btn_raw = raw;
      reset   = rst;
      model_step(raw, rst, e);
      exp_q.push_back(e);
      active = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL queue_empty at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (level !== e.level || rise !== e.rise || fall !== e.fall || long_press !== e.lp) begin
            errors++;
            $display("FAIL outputs at %0t: level %b/%b rise %b/%b fall %b/%b long_press %b/%b (got/expected)",
                     $time, level, e.level, rise, e.rise, fall, e.fall, long_press, e.lp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [N-1:0] cur;
    int rem[N];
    // held at reset, then re-debounced on release
    drive(5'b11111, 1'b0, 3);
    drive(5'b11111, 1'b1, 10);
    drive(5'b00000, 1'b1, 10);
    // clean press on up
    drive(5'b10000, 1'b1, 8);
    drive(5'b00000, 1'b1, 10);
    // bounce on left, then steady
    for (int k = 0; k < 6; k++) drive((k % 2 == 0) ? 5'b01000 : 5'b00000, 1'b1, 1);
    drive(5'b01000, 1'b1, 10);
    drive(5'b00000, 1'b1, 10);
    // long hold on middle
    drive(5'b00001, 1'b1, 20);
    drive(5'b00000, 1'b1, 10);
    // release glitch on down while high
    drive(5'b00010, 1'b1, 13);
    drive(5'b00000, 1'b1, 2);
    drive(5'b00010, 1'b1, 15);
    drive(5'b00000, 1'b1, 10);
    // reset while right is in its release check
    drive(5'b00100, 1'b1, 12);
    drive(5'b00000, 1'b1, 4);
    drive(5'b00000, 1'b0, 1);
    drive(5'b00000, 1'b1, 12);
    // randomized bouncy presses with occasional resets
    cur = '0;
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 16));
        end
      end
      drive(cur, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, 1);
    end
    drive(5'b00000, 1'b1, 10);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
